// File: rtl/seq_detect_ctrl.sv
// Run-control and event sequencer for a serial pattern matcher:
// arms/disarms, guards the fill window, counts and stretches hits.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             din,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    output logic             busy,
    output logic             find_out,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(PAT_W);
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [HW-1:0] HOLD_V    = HW'(HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HUNT,
        FINISH
    } state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   shift, shift_n;
    logic [PAT_W-1:0]   pat, pat_n;
    logic [CNT_W-1:0]   tgt, tgt_n;
    logic [CNT_W-1:0]   cnt_n, cnt_inc;
    logic [FW-1:0]      fill_cnt, fill_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic               done_q, done_n;
    logic               accept;

    assign accept   = start & ~stop;
    assign cnt_inc  = (&match_cnt) ? match_cnt : match_cnt + CNT_ONE;
    assign busy     = (state == FILL) || (state == HUNT);
    assign find_out = (hold_cnt != '0);
    assign done     = done_q;

    always_comb begin
        state_n = state;
        shift_n = shift;
        pat_n   = pat;
        tgt_n   = tgt;
        cnt_n   = match_cnt;
        fill_n  = fill_cnt;
        done_n  = done_q;
        hold_n  = (hold_cnt != '0) ? hold_cnt - HOLD_ONE : '0;
        unique case (state)
            IDLE, FINISH: begin
                if (accept) begin
                    pat_n   = cfg_pattern;
                    tgt_n   = cfg_target;
                    shift_n = '0;
                    fill_n  = '0;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                    state_n = FILL;
                end else if (state == FINISH && stop) begin
                    state_n = IDLE;
                end
            end
            FILL: begin
                if (stop) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else begin
                    shift_n = {din, shift[PAT_W-1:1]};
                    if (fill_cnt == FILL_LAST) begin
                        state_n = HUNT;
                    end else begin
                        fill_n = fill_cnt + FILL_ONE;
                    end
                end
            end
            HUNT: begin
                if (stop) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else begin
                    shift_n = {din, shift[PAT_W-1:1]};
                    // compare uses the shift value before this edge's sample
                    if (shift == pat) begin
                        cnt_n  = cnt_inc;
                        hold_n = HOLD_V;
                        if (tgt != '0 && cnt_inc == tgt) begin
                            state_n = FINISH;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            shift     <= '0;
            pat       <= '0;
            tgt       <= '0;
            match_cnt <= '0;
            fill_cnt  <= '0;
            hold_cnt  <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            pat       <= pat_n;
            tgt       <= tgt_n;
            match_cnt <= cnt_n;
            fill_cnt  <= fill_n;
            hold_cnt  <= hold_n;
            done_q    <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: vector table plus hand sequences
// for reset, fill guard and counter saturation.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       din = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] cfg_pattern = '0;
    logic [7:0] cfg_target = '0;
    logic       busy, find_out, done;
    logic [7:0] match_cnt;
    logic       busy_s, find_s, done_s;
    logic [1:0] cnt_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .HOLD(4)) u_dut (
        .clk(clk), .rst_(rst_), .din(din), .start(start), .stop(stop),
        .cfg_pattern(cfg_pattern), .cfg_target(cfg_target),
        .busy(busy), .find_out(find_out), .done(done),
        .match_cnt(match_cnt)
    );

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(2), .HOLD(4)) u_sat (
        .clk(clk), .rst_(rst_), .din(din), .start(start), .stop(stop),
        .cfg_pattern(cfg_pattern), .cfg_target(cfg_target[1:0]),
        .busy(busy_s), .find_out(find_s), .done(done_s),
        .match_cnt(cnt_s)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       din;
        logic [3:0] pat;
        logic [7:0] tgt;
        logic       busy;
        logic       fnd;
        logic       dn;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic s, logic p, logic d,
                                logic [3:0] pt, logic [7:0] tg,
                                logic b, logic f, logic dn,
                                logic [7:0] c);
        vec_t v;
        v.start = s; v.stop = p; v.din = d;
        v.pat = pt; v.tgt = tg;
        v.busy = b; v.fnd = f; v.dn = dn; v.cnt = c;
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] P1 = 4'b1001;
    localparam logic [3:0] P3 = 4'b0011;

    initial begin
        logic [15:0] s4;
        int ec;

        // reset state
        tick();
        tick();
        chk("rst_busy", 0, busy, 0);
        chk("rst_find", 0, find_out, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_cnt", 0, match_cnt, 0);
        chk("rst_cnt_s", 0, cnt_s, 0);
        @(negedge clk);
        rst_ = 1'b1;

        // overlap, retrigger
        add(1,0,0,P1,0, 1,0,0,0);
        add(0,0,1,P1,0, 1,0,0,0);
        add(0,0,0,P1,0, 1,0,0,0);
        add(0,0,0,P1,0, 1,0,0,0);
        add(0,0,1,P1,0, 1,0,0,0);
        add(0,0,0,P1,0, 1,1,0,1);
        add(0,0,0,P1,0, 1,1,0,1);
        add(0,0,1,P1,0, 1,1,0,1);
        add(0,0,0,P1,0, 1,1,0,2);
        add(0,0,0,P1,0, 1,1,0,2);
        add(0,0,0,P1,0, 1,1,0,2);
        add(0,0,0,P1,0, 1,1,0,2);
        add(0,0,0,P1,0, 1,0,0,2);
        add(0,1,0,P1,0, 0,0,0,2);

        // bit order
        add(1,0,0,P3,0, 1,0,0,0);
        add(0,0,1,P3,0, 1,0,0,0);
        add(0,0,1,P3,0, 1,0,0,0);
        add(0,0,0,P3,0, 1,0,0,0);
        add(0,0,0,P3,0, 1,0,0,0);
        add(0,0,0,P3,0, 1,1,0,1);
        add(0,0,0,P3,0, 1,1,0,1);
        add(0,0,0,P3,0, 1,1,0,1);
        add(0,0,0,P3,0, 1,1,0,1);
        add(0,0,0,P3,0, 1,0,0,1);
        add(0,1,0,P3,0, 0,0,0,1);
        add(1,0,0,P3,0, 1,0,0,0);
        add(0,0,0,P3,0, 1,0,0,0);
        add(0,0,0,P3,0, 1,0,0,0);
        add(0,0,1,P3,0, 1,0,0,0);
        add(0,0,1,P3,0, 1,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,1,P3,0, 1,0,0,0);
        add(0,1,0,P3,0, 0,0,0,0);

        // auto-stop at target 3 with five occurrences offered
        s4 = 16'b1001001001001001;
        add(1,0,0,P1,3, 1,0,0,0);
        for (int k = 1; k <= 16; k++) begin
            if (k <= 4)       add(0,0,s4[k-1],P1,3, 1,0,0,0);
            else if (k <= 7)  add(0,0,s4[k-1],P1,3, 1,1,0,1);
            else if (k <= 10) add(0,0,s4[k-1],P1,3, 1,1,0,2);
            else if (k <= 14) add(0,0,s4[k-1],P1,3, 0,1,1,3);
            else              add(0,0,s4[k-1],P1,3, 0,0,1,3);
        end
        add(1,0,0,P1,0, 1,0,0,0);
        add(0,1,0,P1,0, 0,0,0,0);

        // abort and priority
        add(1,0,0,P1,0, 1,0,0,0);
        add(0,0,1,P1,0, 1,0,0,0);
        add(0,0,0,P1,0, 1,0,0,0);
        add(0,0,0,P1,0, 1,0,0,0);
        add(0,0,1,P1,0, 1,0,0,0);
        add(0,0,0,P1,0, 1,1,0,1);
        add(0,1,0,P1,0, 0,0,0,1);
        add(1,1,0,P1,0, 0,0,0,1);
        add(1,0,0,P1,0, 1,0,0,0);
        add(0,0,1,P1,0, 1,0,0,0);
        add(1,0,0,4'b0000,0, 1,0,0,0);
        add(0,0,0,4'b0000,0, 1,0,0,0);
        add(0,0,1,4'b0000,0, 1,0,0,0);
        add(0,0,0,4'b0000,0, 1,1,0,1);
        add(0,1,0,4'b0000,0, 0,0,0,1);

        foreach (vq[i]) begin
            start = vq[i].start;
            stop = vq[i].stop;
            din = vq[i].din;
            cfg_pattern = vq[i].pat;
            cfg_target = vq[i].tgt;
            tick();
            chk("busy", i, busy, vq[i].busy);
            chk("find_out", i, find_out, vq[i].fnd);
            chk("done", i, done, vq[i].dn);
            chk("match_cnt", i, match_cnt, vq[i].cnt);
        end
        start = 0;
        stop = 0;

        // fill guard and saturation
        cfg_pattern = 4'b0000;
        cfg_target = 0;
        din = 0;
        start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ec = (k >= 5) ? k - 4 : 0;
            chk("fg_find", k, find_out, (k >= 5) ? 1 : 0);
            chk("fg_cnt", k, match_cnt, ec);
            chk("sat_cnt", k, cnt_s, (ec > 3) ? 3 : ec);
            chk("sat_find", k, find_s, (k >= 5) ? 1 : 0);
        end
        stop = 1;
        tick();
        stop = 0;

        // async reset mid-hunt
        cfg_pattern = P1;
        start = 1;
        tick();
        start = 0;
        s4 = 16'b0000000001001001;
        for (int k = 0; k < 7; k++) begin
            din = s4[k];
            tick();
        end
        din = 0;
        tick();
        chk("pre_find", 0, find_out, 1);
        chk("pre_cnt", 0, match_cnt, 2);
        #3;
        rst_ = 1'b0;
        #1;
        chk("arst_busy", 0, busy, 0);
        chk("arst_find", 0, find_out, 0);
        chk("arst_done", 0, done, 0);
        chk("arst_cnt", 0, match_cnt, 0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int k = 0; k < 8; k++) begin
            din = s4[k];
            tick();
            chk("post_busy", k, busy, 0);
            chk("post_cnt", k, match_cnt, 0);
            chk("post_find", k, find_out, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-control and event sequencer for the serial pattern-detect datapath. It arms and disarms a programmable PAT_W-bit serial matcher and guards the window until PAT_W fresh bits are captured. It counts matches, stretches each hit into a HOLD-cycle find_out pulse, and stops itself after a programmed number of hits. It sits between the serial input pin and the software control/status registers.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of match counter and target
HOLD, 4, find_out stretch length in cycles (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst_  in  1  asynchronous active-low reset
din  in  1  serial data, sampled every posedge in FILL/HUNT
start  in  1  single-cycle arm request; latches cfg_*
stop  in  1  single-cycle abort request
cfg_pattern  in  PAT_W  pattern to match
cfg_target  in  CNT_W  hits before auto-stop; 0 = run until stop
busy  out  1  high in FILL or HUNT
find_out  out  1  stretched hit indication
done  out  1  target reached; held until next accepted start
match_cnt  out  CNT_W  hits since last accepted start, saturating

Behaviour:
- Reset (rst_=0, async): state=IDLE; shift, fill count, hold count, match_cnt, and latched cfg all clear to 0; busy=0, find_out=0, done=0.
- Shift register: every posedge in FILL/HUNT, shift <= {din, shift[PAT_W-1:1]}. The oldest bit lands in the LSB, so the first serial bit of the pattern is cfg_pattern[0].
- States:
  - IDLE: if start & !stop, latch cfg_pattern/cfg_target, clear shift, fill count, match_cnt and done, then go to FILL. Otherwise stay.
  - FILL: sample din. The fill count increments; on the PAT_W-th sample go to HUNT. No compare is made in FILL, so the reset-cleared shift never produces a hit.
  - HUNT: sample din and compare the registered shift to the latched pattern.
    - On equality, register a hit: match_cnt++ (holds at all-ones) and the hold counter loads HOLD.
    - If cfg_target!=0 and the new count equals cfg_target, go to DONE.
    - Overlapping matches count individually.
  - DONE: done=1, busy=0, no sampling, no counting. start & !stop is accepted exactly as in IDLE. stop returns to IDLE and keeps done=1.
- stop in FILL/HUNT: go to IDLE next edge. The hold counter clears, so find_out=0 on the next cycle. match_cnt is retained.
- start while busy is ignored. When start and stop arrive in the same cycle, stop wins.
- find_out = (hold counter != 0). The counter decrements each cycle when nonzero. A new hit reloads HOLD (retrigger, no gap). The hold continues to run out after entering DONE.
- Latency: the last pattern bit is sampled at edge t. The hit compare occurs at edge t+1, and find_out and match_cnt update at edge t+1. find_out is high for HOLD cycles after the last hit.
- Minimum start-to-first-hit: start edge s, samples at s+1..s+PAT_W, first possible find_out at edge s+PAT_W+1.
- Asserting rst_ mid-operation aborts immediately to reset values. No partial state survives.

Test Plan:
1. Reset: run HUNT with find_out=1 and match_cnt=2, then pulse rst_ low between edges -> all outputs 0 asynchronously, state IDLE; after release, din activity has no effect until start.
2. Overlap: cfg_pattern=4'b1001, target=0, stream 1,0,0,1,0,0,1 -> match_cnt=2. find_out rises one cycle after the 4th bit and stays continuously high until 4 cycles after the second hit (retrigger, no gap).
3. Bit order: cfg_pattern=4'b0011, stream 1,1,0,0 -> one hit, match_cnt=1. A fresh start with stream 0,0,1,1 -> match_cnt=0, find_out never high.
4. Auto-stop: pattern 1001, target=3, stream with 5 occurrences -> done=1 and busy=0 after the 3rd hit, match_cnt=3 frozen. The final hold still lasts 4 cycles. done clears on the next accepted start.
5. Abort/priority: stop during a hold -> find_out=0 the next cycle, busy=0, match_cnt retained. start+stop together in IDLE -> stays IDLE. start while busy -> ignored, cfg unchanged.
6. Fill guard and saturation:
   - cfg_pattern=0, din held 0 -> no hit until edge s+5; after that, a hit every cycle.
   - With CNT_W=2 -> match_cnt saturates at 3 and find_out stays high.
